// File: rtl/lemmings_pkg.sv
// lemmings_pkg: world state encoding and walker status layout shared by world, walker and benches.
package lemmings_pkg;
  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_DIG    = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;
  typedef struct packed {
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
  } walker_status_t;
  localparam walker_status_t WS_SPLAT = '0;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/lemmings_hole_map.sv
// lemmings_hole_map: per-cell pit map, reloaded on reset, single-bit clear when a pit is filled.
module lemmings_hole_map #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W = 4,
  parameter logic [TRACK_LEN-1:0] HOLE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [POS_W-1:0] idx,
  output logic             hole
);
  logic [TRACK_LEN-1:0] map;
  always_ff @(posedge clk)
    if (rst) map <= HOLE_MASK;
    else if (clr) map[idx] <= 1'b0;
  assign hole = map[idx];
endmodule

// File: rtl/lemmings_world.sv
// lemmings_world: 1-D terrain responder producing bump/ground/dig sensor inputs for the lemming walker.
module lemmings_world
  import lemmings_pkg::*;
#(
  parameter int TRACK_LEN = 16,
  parameter int START_POS = 0,
  parameter logic [TRACK_LEN-1:0] HOLE_MASK = '0,
  parameter int STEP_CYCLES = 4,
  parameter int PIT_DEPTH = 4,
  parameter int DIG_CYCLES = 3,
  parameter int DIG_DEPTH = 12,
  localparam int POS_W = $clog2(TRACK_LEN)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  input  logic             digging,
  input  logic             dig_cmd,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic             dig,
  output logic [POS_W-1:0] pos
);
  localparam int CNT_W = $clog2(max3(PIT_DEPTH, DIG_DEPTH, DIG_CYCLES) + 1);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(TRACK_LEN - 1);
  logic [1:0] state;
  logic [CNT_W-1:0] fall_cnt, dig_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic hole, clr, move_l, move_r, step_hit;
  walker_status_t ws;
  assign ws = '{walk_left, walk_right, aaah, digging};
  // a screaming walker is airborne, so its stale walk bits never move it
  assign move_l = ws.walk_left & ~ws.walk_right & ~ws.aaah;
  assign move_r = ws.walk_right & ~ws.walk_left & ~ws.aaah;
  assign step_hit = step_cnt == STEP_W'(STEP_CYCLES - 1);
  assign clr = (state == ST_FALL) && (fall_cnt == CNT_W'(1));
  assign ground = state != ST_FALL;
  lemmings_hole_map #(.TRACK_LEN(TRACK_LEN), .POS_W(POS_W), .HOLE_MASK(HOLE_MASK)) u_hole_map (
    .clk(sys_clk),
    .rst(sys_rst),
    .clr(clr),
    .idx(pos),
    .hole(hole)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_GROUND;
      pos <= POS_W'(START_POS);
      fall_cnt <= '0;
      dig_cnt <= '0;
      step_cnt <= '0;
      bump_left <= 1'b0;
      bump_right <= 1'b0;
      dig <= 1'b0;
    end else begin
      bump_left <= 1'b0;
      bump_right <= 1'b0;
      dig <= dig_cmd & (state == ST_GROUND);
      step_cnt <= '0;
      if (state == ST_GROUND) begin
        if (hole) begin
          state <= ST_FALL;
          fall_cnt <= CNT_W'(PIT_DEPTH);
        end else if (ws.digging) begin
          if (DIG_CYCLES == 1) begin
            state <= ST_FALL;
            fall_cnt <= CNT_W'(DIG_DEPTH);
          end else begin
            state <= ST_DIG;
            dig_cnt <= CNT_W'(1);
          end
        end else if (ws.walk_left && ws.walk_right) begin
          step_cnt <= step_cnt;
        end else if (move_l || move_r) begin
          if (!step_hit) step_cnt <= step_cnt + 1'b1;
          else if (move_l) begin
            if (pos == '0) bump_left <= 1'b1;
            else pos <= pos - 1'b1;
          end else begin
            if (pos == LAST) bump_right <= 1'b1;
            else pos <= pos + 1'b1;
          end
        end
      end else if (state == ST_DIG) begin
        if (!ws.digging) begin
          state <= ST_GROUND;
          dig_cnt <= '0;
        end else if (dig_cnt == CNT_W'(DIG_CYCLES - 1)) begin
          state <= ST_FALL;
          fall_cnt <= CNT_W'(DIG_DEPTH);
          dig_cnt <= '0;
        end else dig_cnt <= dig_cnt + 1'b1;
      end else if (state == ST_FALL) begin
        fall_cnt <= fall_cnt - 1'b1;
        if (fall_cnt == CNT_W'(1)) state <= ST_GROUND;
      end else state <= ST_GROUND;
    end
  end
endmodule

// File: doc/lemmings_world.md
# lemmings_world

Terrain/environment responder for the lemming walker FSM. It consumes the walker's status outputs (walk_left, walk_right, aaah, digging) and produces its sensor inputs (bump_left, bump_right, ground, dig). It models a 1-D track with end walls, pre-set pits and diggable floor. It sits opposite the walker in the lemmings demo and in closed-loop benches as the stimulus source and scoreboard reference.

## Interface
- TRACK_LEN, 16: number of track cells, ≥2; POS_W = $clog2(TRACK_LEN)
- START_POS, 0: cell index after reset
- HOLE_MASK, 0: TRACK_LEN-bit pit map; bit i=1 means cell i has no floor
- STEP_CYCLES, 4: walking cycles per one-cell move, ≥1
- PIT_DEPTH, 4: fall duration through a pit, cycles, ≥1
- DIG_CYCLES, 3: consecutive digging cycles needed to break the floor, ≥1
- DIG_DEPTH, 12: fall duration after dig-through, cycles, ≥1
- sys_clk  in  1  clock, all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- walk_left, walk_right, aaah, digging  in  1 each  walker status
- dig_cmd  in  1  user dig request
- bump_left, bump_right  out  1 each  one-cycle wall-hit pulses
- ground  out  1  floor present under the lemming
- dig  out  1  dig request to the walker
- pos  out  POS_W  current cell

## Operation
- World FSM states: ST_GROUND, ST_DIG, ST_FALL. ground = (state != ST_FALL), decoded from state.
- hole_map register is loaded from HOLE_MASK at reset.
- ST_GROUND, evaluated in this priority order:
  - If hole_map[pos]=1: go to ST_FALL, fall_cnt ← PIT_DEPTH.
  - Else if digging: go to ST_DIG, dig_cnt ← 1. If DIG_CYCLES=1, go directly to ST_FALL with fall_cnt ← DIG_DEPTH.
  - Else if walk_left or walk_right: step_cnt increments.
- Step action, taken when step_cnt = STEP_CYCLES-1; step_cnt then clears:
  - walk_left: at pos=0, bump_left ← 1 for one cycle and pos holds; otherwise pos ← pos-1.
  - walk_right: the same at TRACK_LEN-1 with bump_right and pos+1.
  - Both walk inputs high: no move and step_cnt holds (illegal walker output).
- step_cnt clears whenever the state is not ST_GROUND or neither walk input is high.
- ST_DIG:
  - digging=0: return to ST_GROUND, dig_cnt ← 0.
  - dig_cnt = DIG_CYCLES-1: go to ST_FALL, fall_cnt ← DIG_DEPTH.
  - Otherwise dig_cnt increments.
- ST_FALL: fall_cnt decrements each cycle. On fall_cnt = 1: go to ST_GROUND and clear hole_map[pos], so the landing fills the pit. pos is frozen during the fall.
- dig is registered: dig ← dig_cmd & (state == ST_GROUND).
- Splatted walker (all status outputs 0): the world stays in ST_GROUND indefinitely with no moves.
- Counter widths: fall_cnt and dig_cnt are $clog2(max(PIT_DEPTH, DIG_DEPTH, DIG_CYCLES)+1) bits; step_cnt is $clog2(STEP_CYCLES+1) bits. No counter wraps.

## Timing
- Reset values: state ST_GROUND, ground=1, bump_left=0, bump_right=0, dig=0, pos=START_POS, all counters 0, hole_map=HOLE_MASK.
- Reset asserted mid-fall or mid-dig restores all reset values on the next edge; filled pits reappear.
- A move into a pit cell at edge N drives ground=0 from edge N+1.
- ground stays 0 for exactly PIT_DEPTH or DIG_DEPTH cycles.
- bump pulses are registered and last exactly one cycle. They repeat every STEP_CYCLES cycles while the walker keeps pushing into the wall.
- dig lags dig_cmd by one cycle.
- A pit at START_POS makes ground fall to 0 on the first cycle after reset.

## Structure
- lemmings_pkg holds:
  - World state encoding ST_GROUND/ST_DIG/ST_FALL.
  - Walker status encoding constants, shared with the walker and benches.
- One sub-module: lemmings_hole_map.
  - TRACK_LEN-bit register with reset load from HOLE_MASK.
  - Indexed read at pos.
  - Single-bit clear strobe.

## Test plan
Bench parameters for all scenarios: TRACK_LEN=8, START_POS=3, STEP_CYCLES=2, HOLE_MASK=8'b0010_0000, PIT_DEPTH=4, DIG_CYCLES=3, DIG_DEPTH=12.
- Reset: 2 cycles of sys_rst=1 → ground=1, bump_left=0, bump_right=0, dig=0, pos=3.
- Left wall: walk_left held → pos 2, 1, 0 at cycles 2, 4, 6; bump_left pulses 1 cycle at cycle 8 with pos=0; pulse repeats at cycle 10.
- Pit: walk_right held → pos=4, then pos=5; ground=0 for exactly 4 cycles; then ground=1 and pit bit 5 is cleared. Walking back over cell 5 → no fall.
- Dig-through: dig_cmd=1 → dig=1 one cycle later; digging held 3 cycles → ground=0 for 12 cycles. Closed loop with the walker → walker splats and all its outputs go to 0.
- Aborted dig: digging=1 for 2 cycles then 0 → no fall, dig_cnt=0; a new 3-cycle dig still takes 3 full cycles.
- Reset mid-fall: sys_rst=1 during cycle 2 of the pit fall → next cycle ground=1, pos=3, pit bit 5 restored.
